// File: rtl/line_engine.sv
// Bresenham line rasterizer: CPU loads color/endpoints, pulses trigger, and the
// block emits one frame-buffer word write per pixel on a valid/ready port.
`timescale 1ns/1ps
module line_engine #(
  parameter logic [31:0] FB_BASE = 32'h1000_0000,
  parameter int unsigned COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_color,
  input  logic [COORD_W-1:0] line_point,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               line_ready,
  output logic [31:0]        fb_addr,
  output logic [31:0]        fb_din,
  output logic [3:0]         fb_we,
  output logic               fb_valid,
  input  logic               fb_ready
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               color_q, color_d;
  logic [COORD_W-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]        cx_q, cx_d, cy_q, cy_d, xend_q, xend_d;
  logic [COORD_W-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic signed [COORD_W+1:0] err_q, err_d;
  logic                      steep_q, steep_d, yneg_q, yneg_d;

  // Setup datapath: octant folding of the loaded endpoints
  logic [COORD_W-1:0] adx, ady;
  logic [COORD_W-1:0] ax0, ay0, ax1, ay1;
  logic [COORD_W-1:0] sx0, sy0, sx1, sy1;
  logic               steep, swap;
  logic signed [COORD_W+1:0] err_step;
  logic [COORD_W-1:0] px, py;

  always_comb begin
    adx   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    steep = ady > adx;
    ax0   = steep ? y0_q : x0_q;
    ay0   = steep ? x0_q : y0_q;
    ax1   = steep ? y1_q : x1_q;
    ay1   = steep ? x1_q : y1_q;
    swap  = ax0 > ax1;
    sx0   = swap ? ax1 : ax0;
    sy0   = swap ? ay1 : ay0;
    sx1   = swap ? ax0 : ax1;
    sy1   = swap ? ay0 : ay1;
  end

  assign err_step = err_q - signed'({2'b00, dy_q});

  always_comb begin
    state_d = state_q;
    color_d = color_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xend_d  = xend_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    steep_d = steep_q;
    yneg_d  = yneg_q;
    case (state_q)
      IDLE: begin
        if (line_color_valid) color_d = line_color;
        if (line_x0_valid)    x0_d    = line_point;
        if (line_y0_valid)    y0_d    = line_point;
        if (line_x1_valid)    x1_d    = line_point;
        if (line_y1_valid)    y1_d    = line_point;
        if (line_trigger)     state_d = SETUP;
      end
      SETUP: begin
        steep_d = steep;
        cx_d    = sx0;
        cy_d    = sy0;
        xend_d  = sx1;
        dx_d    = sx1 - sx0;
        dy_d    = (sy1 >= sy0) ? (sy1 - sy0) : (sy0 - sy1);
        err_d   = signed'({2'b00, 1'b0, dx_d[COORD_W-1:1]});
        yneg_d  = !(sy0 < sy1);
        state_d = DRAW;
      end
      DRAW: begin
        if (fb_ready) begin
          if (cx_q == xend_q) begin
            state_d = IDLE;
          end else begin
            cx_d  = cx_q + 1'b1;
            err_d = err_step;
            if (err_step[COORD_W+1]) begin
              cy_d  = yneg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
              err_d = err_step + signed'({2'b00, dx_q});
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      color_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xend_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      steep_q <= 1'b0;
      yneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xend_q  <= xend_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      steep_q <= steep_d;
      yneg_q  <= yneg_d;
    end
  end

  // Steep lines were walked with x/y exchanged; swap back for the address
  assign px         = steep_q ? cy_q : cx_q;
  assign py         = steep_q ? cx_q : cy_q;
  assign fb_valid   = (state_q == DRAW);
  assign line_ready = (state_q == IDLE);
  assign fb_we      = fb_valid ? '1 : '0;
  assign fb_din     = color_q;
  assign fb_addr    = fb_valid ? {FB_BASE[31:22], py, px, 2'b00} : '0;

endmodule
